qdr_slave_buffer: RTL
=====================

# qdr_slave_buffer

Request buffer between user fabric logic and the slave port of the QDR sniffer/arbiter. It absorbs the cycles where the arbiter withholds `slave_ack` while the backdoor owns the QDR. User logic can therefore issue one request per cycle, with no combinational dependence on arbitration. It also registers returning read data and tracks outstanding reads, for flow control and error detection.

## Interface
Parameters:
- `QDR_DATA_WIDTH`, 18: QDR word width; data buses are 2*QDR_DATA_WIDTH.
- `QDR_BW_WIDTH`, 2: byte-enable width per word; BE buses are 2*QDR_BW_WIDTH.
- `DEPTH_LOG2`, 3: FIFO depth = 2**DEPTH_LOG2 entries.
- `AFULL_MARGIN`, 2: `usr_afull` asserts when free entries <= AFULL_MARGIN.

Ports:
- `qdr_clk` in 1: single clock for all logic.
- `qdr_rst_n` in 1: one clock; reset is asynchronous and active-low.
- `usr_addr` in 32: request address.
- `usr_wr_strb` in 1: write request.
- `usr_wr_data` in 2*QDR_DATA_WIDTH: write data.
- `usr_wr_be` in 2*QDR_BW_WIDTH: write byte enables.
- `usr_rd_strb` in 1: read request.
- `usr_afull` out 1: almost-full back-pressure.
- `usr_rd_data` out 2*QDR_DATA_WIDTH: registered read data.
- `usr_rd_dvld` out 1: registered read-data valid.
- `slave_addr` out 32: to the arbiter slave port.
- `slave_wr_strb` out 1: to the arbiter slave port.
- `slave_wr_data` out 2*QDR_DATA_WIDTH: to the arbiter slave port.
- `slave_wr_be` out 2*QDR_BW_WIDTH: to the arbiter slave port.
- `slave_rd_strb` out 1: to the arbiter slave port.
- `slave_ack` in 1: arbiter accepts the presented request this cycle.
- `slave_rd_data` in 2*QDR_DATA_WIDTH: read data from the arbiter.
- `slave_rd_dvld` in 1: read data valid from the arbiter.
- `fill` out DEPTH_LOG2+1: current FIFO occupancy.
- `rd_outstanding` out 8: reads issued but not yet returned.
- `overflow` out 1: sticky; a request was dropped because the FIFO was full.
- `rd_underflow` out 1: sticky; `slave_rd_dvld` arrived with zero reads outstanding.

## Operation
- Entry format: {addr, wr, rd, wr_data, wr_be}.
- Push: occurs on any cycle where `usr_wr_strb | usr_rd_strb`. A cycle with both strobes pushes one entry with both flags set; that entry is presented with both slave strobes.
- Head presentation:
  - `slave_wr_strb = head_valid & head.wr` and `slave_rd_strb = head_valid & head.rd`.
  - Addr, data and BE always show the head entry. They hold their last value when empty; values are don't-care when strobes are low.
- Pop: `head_valid & slave_ack`. The head is held unchanged for as many cycles as `slave_ack` stays low.
- Full handling:
  - A push is accepted if `fill < DEPTH` or a pop occurs in the same cycle.
  - Otherwise the request is dropped, `overflow` sets, and `fill` is unchanged.
- Fill arithmetic: push only: +1; pop only: -1; push with pop: unchanged. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- `usr_afull` = `(DEPTH - fill) <= AFULL_MARGIN`, registered from the next-state fill.
- Read tracking:
  - Increment `rd_outstanding` on a pop whose entry has `head.rd` set.
  - Decrement on `slave_rd_dvld`.
  - Both in the same cycle: unchanged.
  - Increment saturates at 255.
  - `slave_rd_dvld` at 0: count stays at 0 and `rd_underflow` sets.
- Read return: `usr_rd_data <= slave_rd_data` and `usr_rd_dvld <= slave_rd_dvld` every cycle. Return order is preserved (the arbiter is in-order).
- Sticky flags clear only on reset.
- Reset values, all async on `qdr_rst_n` low:
  - fill=0, pointers=0, head_valid=0.
  - `slave_wr_strb`=0, `slave_rd_strb`=0, `usr_afull`=0.
  - `usr_rd_dvld`=0, `usr_rd_data`=0.
  - `rd_outstanding`=0, `overflow`=0, `rd_underflow`=0.
- Reset mid-operation: all queued entries are discarded, with no slave strobes after reset asserts. Read data returning after reset deassertion raises `rd_underflow`; this is intended.

## Timing
- Latency from user strobe (cycle N) to slave strobe: N+1 when the FIFO is empty.
- A popped entry leaves in the same cycle as `slave_ack`. The next entry is presented at N+1, so throughput is 1 request per cycle while ack is high.
- `slave_ack` is consumed combinationally into pop and pointer logic only. No slave output depends combinationally on `slave_ack`.
- Read data latency through the block: 1 cycle.
- `fill` and `rd_outstanding` update 1 cycle after the causing event.

## Test plan
- Idle start: release reset, then 1 write (addr 0x10, data 0xABCDE, be 0xF) at cycle 5.
  - `slave_wr_strb` is high at cycle 6 with matching fields, `slave_ack`=1.
  - `fill` returns to 0 at cycle 7.
- Stall: issue 4 consecutive writes while `slave_ack`=0 for 6 cycles.
  - Head is held stable and `fill` reaches 4.
  - On ack release, 4 strobes appear on consecutive cycles in order.
- Overflow: with DEPTH=8 and ack held low, issue 10 writes.
  - `usr_afull` is high once fill>=6, `fill`=8, `overflow`=1.
  - Only the first 8 emerge after ack.
- Full with simultaneous push and pop: fill=8, ack=1, 1 new write in the same cycle.
  - `fill` stays 8 and `overflow` stays 0.
- Combined read/write: one cycle with both strobes, addr 0x20.
  - A single slave cycle shows both strobes.
  - `rd_outstanding` goes 0 to 1, then back to 0 after `slave_rd_dvld`.
  - `usr_rd_dvld` follows one cycle after `slave_rd_dvld`.
- Underflow and reset: pulse `slave_rd_dvld` with 0 outstanding, and `rd_underflow` sets. Then assert `qdr_rst_n` low mid-stall with fill=3.
  - All outputs take reset values immediately (async).
  - No strobes appear after release.

Source files
------------

// File: rtl/qdr_slave_buffer_if.sv
// Bus bundle between user fabric, the request buffer and the arbiter slave port.
// Handshake: slave_wr_strb/slave_rd_strb act as valid, slave_ack as ready; a request
// transfers on any cycle where a strobe and slave_ack are both high, and it is held
// unchanged while slave_ack stays low.
interface qdr_slave_buffer_if #(
  parameter int QDR_DATA_WIDTH = 18,
  parameter int QDR_BW_WIDTH   = 2
);
  logic [31:0]                 usr_addr;
  logic                        usr_wr_strb;
  logic [2*QDR_DATA_WIDTH-1:0] usr_wr_data;
  logic [2*QDR_BW_WIDTH-1:0]   usr_wr_be;
  logic                        usr_rd_strb;
  logic                        usr_afull;
  logic [2*QDR_DATA_WIDTH-1:0] usr_rd_data;
  logic                        usr_rd_dvld;

  logic [31:0]                 slave_addr;
  logic                        slave_wr_strb;
  logic [2*QDR_DATA_WIDTH-1:0] slave_wr_data;
  logic [2*QDR_BW_WIDTH-1:0]   slave_wr_be;
  logic                        slave_rd_strb;
  logic                        slave_ack;
  logic [2*QDR_DATA_WIDTH-1:0] slave_rd_data;
  logic                        slave_rd_dvld;

  // The buffer itself.
  modport slave (
    input  usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
    output usr_afull, usr_rd_data, usr_rd_dvld,
    output slave_addr, slave_wr_strb, slave_wr_data, slave_wr_be, slave_rd_strb,
    input  slave_ack, slave_rd_data, slave_rd_dvld
  );

  // User fabric plus arbiter, as seen from outside the buffer.
  modport master (
    output usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
    input  usr_afull, usr_rd_data, usr_rd_dvld,
    input  slave_addr, slave_wr_strb, slave_wr_data, slave_wr_be, slave_rd_strb,
    output slave_ack, slave_rd_data, slave_rd_dvld
  );
endinterface

// File: rtl/qdr_slave_buffer.sv
// Request FIFO in front of the QDR arbiter slave port, with registered read return
// and outstanding-read tracking.
module qdr_slave_buffer #(
  parameter int QDR_DATA_WIDTH = 18,
  parameter int QDR_BW_WIDTH   = 2,
  parameter int DEPTH_LOG2     = 3,
  parameter int AFULL_MARGIN   = 2
) (
  input  logic                  qdr_clk,
  input  logic                  qdr_rst_n,
  qdr_slave_buffer_if.slave     bus,
  output logic [DEPTH_LOG2:0]   fill,
  output logic [7:0]            rd_outstanding,
  output logic                  overflow,
  output logic                  rd_underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DW    = 2 * QDR_DATA_WIDTH;
  localparam int BW    = 2 * QDR_BW_WIDTH;

  localparam logic [DEPTH_LOG2:0]   DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   MARGIN_C = (DEPTH_LOG2 + 1)'(AFULL_MARGIN);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [31:0]   addr;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } entry_t;

  entry_t                mem [DEPTH];
  entry_t                push_entry;
  entry_t                head_raw;
  entry_t                last_head;
  entry_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   fill_next;
  logic [DEPTH_LOG2:0]   free_next;
  logic                  head_valid;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  rd_inc;
  logic                  rd_dec;
  logic                  afull_q;
  logic [DW-1:0]         rd_data_q;
  logic                  rd_dvld_q;

  assign head_valid = (fill != '0);
  assign push_req   = bus.usr_wr_strb | bus.usr_rd_strb;
  assign pop        = head_valid & bus.slave_ack;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req & ((fill < DEPTH_C) | pop);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = bus.usr_addr;
    push_entry.wr   = bus.usr_wr_strb;
    push_entry.rd   = bus.usr_rd_strb;
    push_entry.data = bus.usr_wr_data;
    push_entry.be   = bus.usr_wr_be;
  end

  always_ff @(posedge qdr_clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign head_raw = mem[rd_ptr];
  // When empty the slave fields keep showing the last entry that left.
  assign head     = head_valid ? head_raw : last_head;

  assign bus.slave_addr    = head.addr;
  assign bus.slave_wr_data = head.data;
  assign bus.slave_wr_be   = head.be;
  assign bus.slave_wr_strb = head_valid & head_raw.wr;
  assign bus.slave_rd_strb = head_valid & head_raw.rd;

  always_comb begin
    fill_next = fill;
    unique case ({push_ok, pop})
      2'b10:   fill_next = fill + FILL_ONE;
      2'b01:   fill_next = fill - FILL_ONE;
      default: fill_next = fill;
    endcase
  end

  assign free_next = DEPTH_C - fill_next;

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      afull_q   <= 1'b0;
      overflow  <= 1'b0;
      last_head <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_head <= head_raw;
      end
      fill    <= fill_next;
      afull_q <= (free_next <= MARGIN_C);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  assign bus.usr_afull = afull_q;

  assign rd_inc = pop & head_raw.rd;
  assign rd_dec = bus.slave_rd_dvld;

  // Read issue and return in the same cycle cancel; the counter saturates at both ends.
  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      rd_outstanding <= '0;
      rd_underflow   <= 1'b0;
    end else begin
      if (rd_inc && !rd_dec) begin
        if (rd_outstanding != 8'hFF) rd_outstanding <= rd_outstanding + 8'd1;
      end else if (!rd_inc && rd_dec) begin
        if (rd_outstanding == 8'd0) rd_underflow   <= 1'b1;
        else                        rd_outstanding <= rd_outstanding - 8'd1;
      end
    end
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      rd_data_q <= '0;
      rd_dvld_q <= 1'b0;
    end else begin
      rd_data_q <= bus.slave_rd_data;
      rd_dvld_q <= bus.slave_rd_dvld;
    end
  end

  assign bus.usr_rd_data = rd_data_q;
  assign bus.usr_rd_dvld = rd_dvld_q;

endmodule
